bp_perf_cnt: RTL and testbench
==============================

BP_PERF_CNT -- requirements
Module: bp_perf_cnt

Interface
REQ-001 SHALL have parameter P, default cvw::cvw_t config, meaning core configuration; unit exists only when P.ZIHPM_SUPPORTED.
REQ-002 SHALL have parameter CNT_W, default 64, meaning counter width in bits (legal range 8..64).
REQ-003 SHALL have port clk  in  1  meaning sole clock.
REQ-004 SHALL have port reset_n  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port StallW  in  1  meaning writeback stall.
REQ-006 SHALL have port FlushW  in  1  meaning writeback flush.
REQ-007 SHALL have port InstrValidM  in  1  meaning M-stage instruction valid.
REQ-008 SHALL have port InstrClassM  in  4  meaning one-hot class {call, return, jump, branch}.
REQ-009 SHALL have port EvWrongM  in  5  meaning {BPWrong, IClassWrong, RASPredPCWrong, BTAWrong, BPDirPredWrong}.
REQ-010 SHALL have port CntInhibit  in  8  meaning per-counter count inhibit.
REQ-011 SHALL have port CntRdEn, CntRdSel[2:0], CntRdData[CNT_W]  in/in/out  meaning read port.
REQ-012 SHALL have port CntWrEn, CntWrSel[2:0], CntWrData[CNT_W]  in/in/in  meaning write port.
REQ-013 SHALL have port ClearReq  in  1  meaning start clear sweep.
REQ-014 SHALL have port ClearBusy, ClearDone  out/out  1  meaning sweep active, one-cycle completion pulse.
REQ-015 SHALL have port Ovf  out  8  meaning sticky per-counter overflow.
REQ-016 SHALL have port OvfIrq  out  1  meaning OR of Ovf.

Function
REQ-017 SHALL register InstrValidM, InstrClassM and EvWrongM into a W-stage register enabled by ~StallW and cleared by FlushW.
REQ-018 SHALL assert commit for a W-stage instruction when InstrValidW & ~StallW & ~FlushW.
REQ-019 SHALL map events to counters as: 0 branch, 1 branch & DirWrong, 2 (jump | call) & ~return, 3 BTAWrong, 4 return, 5 RASWrong, 6 IClassWrong, 7 BPWrong.
REQ-020 SHALL, for each event active at commit with CntInhibit[i]=0, increment counter i by exactly 1 on the next clock edge.
REQ-021 SHALL wrap a counter from all-ones to 0 and set Ovf[i] in the same edge.
REQ-022 SHALL give CntWrEn priority over a same-cycle increment to the same counter: the counter takes CntWrData and Ovf[CntWrSel] clears.
REQ-023 SHALL register CntRdData one cycle after CntRdEn, returning the pre-edge value of the selected counter, and SHALL hold CntRdData otherwise.
REQ-024 SHALL implement FSM IDLE->CLEAR on ClearReq and run a 3-bit index 0..7 in CLEAR, zeroing one counter and its Ovf bit per cycle.
REQ-025 SHALL assert ClearBusy in CLEAR, pulse ClearDone for one cycle after index 7 is cleared, and return to IDLE.
REQ-026 SHALL ignore ClearReq while in CLEAR.
REQ-027 SHALL suppress all increments and ignore CntWrEn while in CLEAR, and SHALL continue serving reads.
REQ-028 SHALL latch Ovf bits until written or cleared; OvfIrq SHALL be combinational OR of Ovf.

Reset
REQ-029 SHALL, on reset_n low at any time (including mid-sweep), asynchronously zero all counters, Ovf, the W-stage register and CntRdData, force FSM to IDLE and deassert ClearBusy and ClearDone.

Structure
REQ-030 SHALL place the counter-index constants (BPC_BR .. BPC_BPWRONG) and the FSM state enum in package cvw.
REQ-031 SHALL instantiate sub-module bp_perf_counter eight times; each is one CNT_W counter with inc, wr, clr and sticky overflow, write > clear > inc priority.

Verification
REQ-032 SHALL cover: 3 committed branches, one with DirWrong -> counter0=3, counter1=1, others 0.
REQ-033 SHALL cover: CNT_W=8, write 0xFF to counter4, commit a return -> counter4=0x00, Ovf[4]=1, OvfIrq=1.
REQ-034 SHALL cover: write 0x10 to counter0 in the same cycle as a branch commit -> counter0=0x10, Ovf[0]=0.
REQ-035 SHALL cover: ClearReq with all counters nonzero -> ClearBusy high 8 cycles, ClearDone pulse, all counters 0, and a commit during the sweep is not counted.
REQ-036 SHALL cover: a branch with StallW held 2 cycles, then FlushW -> no increment; CntInhibit[0]=1 with a committed branch -> counter0 unchanged.
REQ-037 SHALL cover: reset_n pulsed low at sweep index 3 -> IDLE, all counters 0, ClearDone never pulses.

Source files
------------

// File: rtl/bp_perf_cnt_pkg.sv
// Shared configuration, counter indices and W-stage payload for the branch-predictor perf counters.
package cvw;

    typedef struct packed {
        logic ZIHPM_SUPPORTED;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{ZIHPM_SUPPORTED: 1'b1};

    localparam int unsigned BPC_NUM   = 8;
    localparam int unsigned BPC_IDX_W = 3;

    // Counter indices
    localparam int unsigned BPC_BR      = 0;
    localparam int unsigned BPC_BRDIR   = 1;
    localparam int unsigned BPC_JMP     = 2;
    localparam int unsigned BPC_BTA     = 3;
    localparam int unsigned BPC_RET     = 4;
    localparam int unsigned BPC_RAS     = 5;
    localparam int unsigned BPC_ICLASS  = 6;
    localparam int unsigned BPC_BPWRONG = 7;

    // Bit positions inside InstrClassM / EvWrongM
    localparam int unsigned ICLS_BR   = 0;
    localparam int unsigned ICLS_JMP  = 1;
    localparam int unsigned ICLS_RET  = 2;
    localparam int unsigned ICLS_CALL = 3;
    localparam int unsigned EV_DIR    = 0;
    localparam int unsigned EV_BTA    = 1;
    localparam int unsigned EV_RAS    = 2;
    localparam int unsigned EV_ICLASS = 3;
    localparam int unsigned EV_BP     = 4;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clrState_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] iclass;
        logic [4:0] wrong;
    } wStage_t;

endpackage

// File: rtl/bp_perf_cnt_counter.sv
// One event counter with sticky overflow; write beats clear beats increment.
module bp_perf_counter #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             wr,
    input  logic [CNT_W-1:0] wrData,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (wr) begin
            cnt <= wrData;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
            if (&cnt) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/bp_perf_cnt.sv
// Branch-predictor performance counters: eight committed-event counters with
// read/write port, sticky overflow and a one-counter-per-cycle clear sweep.
module bp_perf_cnt import cvw::*; #(
    parameter cvw_t        P     = CVW_DEFAULT,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             StallW,
    input  logic             FlushW,
    input  logic             InstrValidM,
    input  logic [3:0]       InstrClassM,
    input  logic [4:0]       EvWrongM,
    input  logic [7:0]       CntInhibit,
    input  logic             CntRdEn,
    input  logic [2:0]       CntRdSel,
    output logic [CNT_W-1:0] CntRdData,
    input  logic             CntWrEn,
    input  logic [2:0]       CntWrSel,
    input  logic [CNT_W-1:0] CntWrData,
    input  logic             ClearReq,
    output logic             ClearBusy,
    output logic             ClearDone,
    output logic [7:0]       Ovf,
    output logic             OvfIrq
);

    assign OvfIrq = |Ovf;

    if (P.ZIHPM_SUPPORTED) begin : gHpm
        wStage_t                 wStage;
        logic                    commit;
        logic [BPC_NUM-1:0]      evt;
        logic [BPC_NUM-1:0]      incVec;
        logic [BPC_NUM-1:0]      wrVec;
        logic [BPC_NUM-1:0]      clrVec;
        logic                    sweeping;
        clrState_t               state;
        clrState_t               stateNext;
        logic [BPC_IDX_W-1:0]    clrIdx;
        logic [BPC_IDX_W-1:0]    clrIdxNext;
        logic                    doneNext;
        logic [CNT_W-1:0]        cntArr [BPC_NUM];

        // W-stage capture of the M-stage instruction
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)     wStage <= '0;
            else if (FlushW)  wStage <= '0;
            else if (!StallW) wStage <= '{valid: InstrValidM, iclass: InstrClassM, wrong: EvWrongM};
        end

        assign commit   = wStage.valid & ~StallW & ~FlushW;
        assign sweeping = (state == CLR_SWEEP);

        always_comb begin
            evt              = '0;
            evt[BPC_BR]      = wStage.iclass[ICLS_BR];
            evt[BPC_BRDIR]   = wStage.iclass[ICLS_BR] & wStage.wrong[EV_DIR];
            evt[BPC_JMP]     = (wStage.iclass[ICLS_JMP] | wStage.iclass[ICLS_CALL]) & ~wStage.iclass[ICLS_RET];
            evt[BPC_BTA]     = wStage.wrong[EV_BTA];
            evt[BPC_RET]     = wStage.iclass[ICLS_RET];
            evt[BPC_RAS]     = wStage.wrong[EV_RAS];
            evt[BPC_ICLASS]  = wStage.wrong[EV_ICLASS];
            evt[BPC_BPWRONG] = wStage.wrong[EV_BP];
        end

        assign incVec = (commit && !sweeping) ? (evt & ~CntInhibit) : '0;

        // Clear sweep: state register plus next-state logic
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= CLR_IDLE;
                clrIdx    <= '0;
                ClearBusy <= 1'b0;
                ClearDone <= 1'b0;
            end else begin
                state     <= stateNext;
                clrIdx    <= clrIdxNext;
                ClearBusy <= (stateNext == CLR_SWEEP);
                ClearDone <= doneNext;
            end
        end

        always_comb begin
            stateNext  = state;
            clrIdxNext = clrIdx;
            doneNext   = 1'b0;
            case (state)
                CLR_IDLE: begin
                    if (ClearReq) begin
                        stateNext  = CLR_SWEEP;
                        clrIdxNext = '0;
                    end
                end
                CLR_SWEEP: begin
                    clrIdxNext = clrIdx + BPC_IDX_W'(1);
                    if (clrIdx == BPC_IDX_W'(BPC_NUM - 1)) begin
                        stateNext = CLR_IDLE;
                        doneNext  = 1'b1;
                    end
                end
                default: stateNext = CLR_IDLE;
            endcase
        end

        for (genvar i = 0; i < BPC_NUM; i++) begin : gCnt
            assign wrVec[i]  = CntWrEn && !sweeping && (CntWrSel == BPC_IDX_W'(i));
            assign clrVec[i] = sweeping && (clrIdx == BPC_IDX_W'(i));

            bp_perf_counter #(.CNT_W(CNT_W)) uCnt (
                .clk     (clk),
                .reset_n (reset_n),
                .inc     (incVec[i]),
                .wr      (wrVec[i]),
                .wrData  (CntWrData),
                .clr     (clrVec[i]),
                .cnt     (cntArr[i]),
                .ovf     (Ovf[i])
            );
        end

        // Read returns the value held before the edge, holds otherwise
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)     CntRdData <= '0;
            else if (CntRdEn) CntRdData <= cntArr[CntRdSel];
        end
    end else begin : gNoHpm
        assign CntRdData = '0;
        assign ClearBusy = 1'b0;
        assign ClearDone = 1'b0;
        assign Ovf       = '0;
    end

endmodule

// File: tb/tb_bp_perf_cnt.sv
// Directed bench for bp_perf_cnt with a cycle-level expectation model and literal spot checks.
module tb_bp_perf_cnt;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             StallW, FlushW, InstrValidM;
    logic [3:0]       InstrClassM;
    logic [4:0]       EvWrongM;
    logic [7:0]       CntInhibit;
    logic             CntRdEn, CntWrEn, ClearReq;
    logic [2:0]       CntRdSel, CntWrSel;
    logic [CNT_W-1:0] CntRdData, CntWrData;
    logic             ClearBusy, ClearDone, OvfIrq;
    logic [7:0]       Ovf;

    int total = 0;
    int bad   = 0;

    bp_perf_cnt #(.P(cvw::CVW_DEFAULT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .StallW(StallW), .FlushW(FlushW),
        .InstrValidM(InstrValidM), .InstrClassM(InstrClassM), .EvWrongM(EvWrongM),
        .CntInhibit(CntInhibit), .CntRdEn(CntRdEn), .CntRdSel(CntRdSel), .CntRdData(CntRdData),
        .CntWrEn(CntWrEn), .CntWrSel(CntWrSel), .CntWrData(CntWrData),
        .ClearReq(ClearReq), .ClearBusy(ClearBusy), .ClearDone(ClearDone),
        .Ovf(Ovf), .OvfIrq(OvfIrq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which counters an instruction of class c with wrong-flags w should bump
    function automatic logic [7:0] evFor(input logic [3:0] c, input logic [4:0] w);
        logic [7:0] e;
        logic isCall, isRet, isJmp, isBr;
        isCall = c[3]; isRet = c[2]; isJmp = c[1]; isBr = c[0];
        e[0] = isBr;
        e[1] = isBr && w[0];
        e[2] = (isJmp || isCall) && !isRet;
        e[3] = w[1];
        e[4] = isRet;
        e[5] = w[2];
        e[6] = w[3];
        e[7] = w[4];
        return e;
    endfunction

    // Expectation model
    logic [CNT_W-1:0] mCnt [8];
    logic [7:0]       mOvf;
    logic             mWV;
    logic [3:0]       mWC;
    logic [4:0]       mWE;
    int               sweepLeft;
    logic             mBusy, mDone;
    logic [CNT_W-1:0] mRd;
    logic [7:0]       mEv;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) mCnt[i] = '0;
            mOvf = '0; mWV = 1'b0; mWC = '0; mWE = '0;
            sweepLeft = 0; mBusy = 1'b0; mDone = 1'b0; mRd = '0;
        end else begin
            if (CntRdEn) mRd = mCnt[CntRdSel];
            mEv = '0;
            if (mWV && !StallW && !FlushW && sweepLeft == 0) mEv = evFor(mWC, mWE) & ~CntInhibit;
            for (int i = 0; i < 8; i++) begin
                if (mEv[i]) begin
                    mCnt[i] = mCnt[i] + 1'b1;
                    if (mCnt[i] == 0) mOvf[i] = 1'b1;
                end
            end
            if (CntWrEn && sweepLeft == 0) begin
                mCnt[CntWrSel] = CntWrData;
                mOvf[CntWrSel] = 1'b0;
            end
            mDone = 1'b0;
            if (sweepLeft > 0) begin
                mCnt[8 - sweepLeft] = '0;
                mOvf[8 - sweepLeft] = 1'b0;
                sweepLeft--;
                if (sweepLeft == 0) mDone = 1'b1;
            end else if (ClearReq) begin
                sweepLeft = 8;
            end
            mBusy = (sweepLeft > 0);
            if (FlushW) begin
                mWV = 1'b0; mWC = '0; mWE = '0;
            end else if (!StallW) begin
                mWV = InstrValidM; mWC = InstrClassM; mWE = EvWrongM;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (reset_n) begin
            chk("model Ovf", 64'(Ovf), 64'(mOvf));
            chk("model OvfIrq", 64'(OvfIrq), 64'(|mOvf));
            chk("model ClearBusy", 64'(ClearBusy), 64'(mBusy));
            chk("model ClearDone", 64'(ClearDone), 64'(mDone));
            chk("model CntRdData", 64'(CntRdData), 64'(mRd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] cls, input logic [4:0] wr);
        InstrValidM = 1'b1; InstrClassM = cls; EvWrongM = wr;
        tick();
        InstrValidM = 1'b0; InstrClassM = '0; EvWrongM = '0;
    endtask

    task automatic wrCnt(input logic [2:0] sel, input logic [CNT_W-1:0] data);
        CntWrEn = 1'b1; CntWrSel = sel; CntWrData = data;
        tick();
        CntWrEn = 1'b0;
    endtask

    task automatic rdExpect(input logic [2:0] sel, input logic [CNT_W-1:0] exp, input string nm);
        CntRdEn = 1'b1; CntRdSel = sel;
        tick();
        CntRdEn = 1'b0;
        chk(nm, 64'(CntRdData), 64'(exp));
    endtask

    task automatic rdAll(input logic [8*CNT_W-1:0] exp, input string nm);
        logic [CNT_W-1:0] v;
        for (int i = 0; i < 8; i++) begin
            v = exp[i*CNT_W +: CNT_W];
            rdExpect(3'(i), v, $sformatf("%s c%0d", nm, i));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int busyCnt, doneCnt;
        reset_n = 1'b0; StallW = 0; FlushW = 0; InstrValidM = 0; InstrClassM = '0; EvWrongM = '0;
        CntInhibit = '0; CntRdEn = 0; CntRdSel = '0; CntWrEn = 0; CntWrSel = '0; CntWrData = '0;
        ClearReq = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("reset Ovf", 64'(Ovf), 64'h0);
        chk("reset ClearBusy", 64'(ClearBusy), 64'h0);
        chk("reset ClearDone", 64'(ClearDone), 64'h0);
        chk("reset CntRdData", 64'(CntRdData), 64'h0);

        // Three branches, one direction-mispredicted
        issue(4'b0001, 5'b00000);
        issue(4'b0001, 5'b00001);
        issue(4'b0001, 5'b00000);
        tick();
        rdAll({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd3}, "three branches");

        // Return wraps counter4 from 0xFF
        wrCnt(3'd4, 8'hFF);
        issue(4'b0100, 5'b00000);
        tick();
        rdExpect(3'd4, 8'h00, "wrap c4");
        chk("wrap Ovf", 64'(Ovf), 64'h10);
        chk("wrap OvfIrq", 64'(OvfIrq), 64'h1);

        // Write beats a same-cycle increment and clears sticky overflow
        wrCnt(3'd0, 8'hFF);
        issue(4'b0001, 5'b00000);
        tick();
        chk("wrap c0 Ovf", 64'(Ovf), 64'h11);
        issue(4'b0001, 5'b00000);
        wrCnt(3'd0, 8'h10);
        rdExpect(3'd0, 8'h10, "write priority c0");
        chk("write priority Ovf", 64'(Ovf), 64'h10);

        // Stalled then flushed branch never counts
        InstrValidM = 1'b1; InstrClassM = 4'b0001;
        tick();
        InstrValidM = 1'b0; InstrClassM = '0; StallW = 1'b1;
        tick(); tick();
        StallW = 1'b0; FlushW = 1'b1;
        tick();
        FlushW = 1'b0;
        tick();
        rdExpect(3'd0, 8'h10, "stall flush c0");

        // Inhibit only counter0
        CntInhibit = 8'h01;
        issue(4'b0001, 5'b00001);
        tick();
        CntInhibit = 8'h00;
        rdExpect(3'd0, 8'h10, "inhibit c0");
        rdExpect(3'd1, 8'h02, "inhibit c1");

        // Remaining event sources
        issue(4'b1000, 5'b00010);
        issue(4'b0010, 5'b00000);
        issue(4'b0100, 5'b00100);
        issue(4'b0000, 5'b11000);
        tick();
        rdAll({8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'h10}, "mixed events");

        // Full clear sweep; commit, write and re-request during it are ignored
        wrCnt(3'd0, 8'h21); wrCnt(3'd1, 8'h22); wrCnt(3'd2, 8'h23); wrCnt(3'd3, 8'h24);
        wrCnt(3'd5, 8'h26); wrCnt(3'd6, 8'h27); wrCnt(3'd7, 8'h28);
        chk("pre-sweep Ovf", 64'(Ovf), 64'h10);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        busyCnt = 0; doneCnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (ClearBusy) busyCnt++;
            if (ClearDone) doneCnt++;
            InstrValidM = (i == 1);
            InstrClassM = (i == 1) ? 4'b0001 : 4'b0000;
            CntWrEn = (i == 3); CntWrSel = 3'd2; CntWrData = 8'hAA;
            ClearReq = (i == 4);
            tick();
        end
        InstrValidM = 1'b0; InstrClassM = '0; CntWrEn = 1'b0; ClearReq = 1'b0;
        chk("sweep busy cycles", 64'(busyCnt), 64'd8);
        chk("sweep done pulses", 64'(doneCnt), 64'd1);
        chk("sweep Ovf", 64'(Ovf), 64'h0);
        rdAll('0, "after sweep");

        // Reset in the middle of a sweep
        wrCnt(3'd5, 8'h55);
        wrCnt(3'd7, 8'h77);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        tick(); tick(); tick();
        chk("mid-sweep busy", 64'(ClearBusy), 64'h1);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (ClearDone) doneCnt++;
            tick();
        end
        chk("reset sweep done pulses", 64'(doneCnt), 64'd0);
        chk("reset sweep busy", 64'(ClearBusy), 64'h0);
        rdAll('0, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
